// File: rtl/pi_gpio_led_rgb_bank.sv
// pi_gpio_led_rgb_bank: bridge between the Pi GPIO core and board I/O.
//   - NUM_LED LEDs driven from the Pi. Each Pi-driven bit is captured and then held.
//   - NUM_LED switches are synchronised, debounced and returned on gpio_i.
//   - NUM_RGB RGB LEDs step through 8 colours on rising edges of their GPIO pin.
//     A free-running PWM counter sets their brightness.
// Optional feature macro: SW_CHANGE_IRQ_EN.
//   - Defined: adds a level switch-change interrupt, acknowledged by a rising
//     edge on gpio_o[IRQ_ACK_BIT].
//   - Undefined: sw_irq is tied low.
module pi_gpio_led_rgb_bank #(
  parameter int GPIO_W      = 28,
  parameter int NUM_LED     = 16,
  parameter int LED_BASE    = 2,
  parameter int NUM_RGB     = 2,
  parameter int RGB_BASE    = 18,
  parameter int PWM_BITS    = 4,
  parameter int RGB_DUTY    = 4,
  parameter int DEBOUNCE    = 50000,
  parameter int IRQ_ACK_BIT = 20
) (
  input  logic               clk_peripheral,
  input  logic               resetn,
  input  logic [GPIO_W-1:0]  gpio_o,
  input  logic [GPIO_W-1:0]  gpio_t,
  output logic [GPIO_W-1:0]  gpio_i,
  input  logic [NUM_LED-1:0] sw,
  output logic [NUM_LED-1:0] led,
  output logic [NUM_RGB-1:0] led_r,
  output logic [NUM_RGB-1:0] led_g,
  output logic [NUM_RGB-1:0] led_b,
  output logic               sw_irq
);

  localparam int                CW      = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]     DB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [PWM_BITS:0] DUTY    = (PWM_BITS + 1)'(RGB_DUTY);

  // LED bank
  logic [NUM_LED-1:0] led_q, led_d;

  // Switch synchroniser and debouncer
  logic [NUM_LED-1:0]         sync1_q, sync2_q;
  logic [NUM_LED-1:0]         db_q, db_d;
  logic [NUM_LED-1:0][CW-1:0] cnt_q, cnt_d;

  // RGB colour stepping and PWM
  logic [NUM_RGB-1:0]       prev_q, prev_d;
  logic [NUM_RGB-1:0][2:0]  idx_q, idx_d;
  logic [PWM_BITS-1:0]      pwm_q, pwm_d;
  logic                     on_s;
  logic [NUM_RGB-1:0]       r_q, g_q, b_q, r_d, g_d, b_d;

  // Pi-driven LED bits take the new value; all other LED bits hold
  always_comb begin
    led_d = led_q;
    for (int k = 0; k < NUM_LED; k++) begin
      if (gpio_t[LED_BASE + k]) begin
        led_d[k] = gpio_o[LED_BASE + k];
      end else begin
        led_d[k] = led_q[k];
      end
    end
  end

  // A switch change is accepted only after it has been stable for DEBOUNCE cycles
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int k = 0; k < NUM_LED; k++) begin
      if (sync2_q[k] == db_q[k]) begin
        cnt_d[k] = {CW{1'b0}};
      end else if (cnt_q[k] == DB_LAST) begin
        db_d[k]  = sync2_q[k];
        cnt_d[k] = {CW{1'b0}};
      end else begin
        cnt_d[k] = cnt_q[k] + CW'(1);
      end
    end
  end

  // Colour index steps on a rising edge of its pin; releasing the pin resets the colour
  always_comb begin
    prev_d = prev_q;
    idx_d  = idx_q;
    for (int c = 0; c < NUM_RGB; c++) begin
      if (gpio_t[RGB_BASE + c]) begin
        prev_d[c] = gpio_o[RGB_BASE + c];
        if (gpio_o[RGB_BASE + c] && !prev_q[c]) begin
          idx_d[c] = idx_q[c] + 3'd1;
        end else begin
          idx_d[c] = idx_q[c];
        end
      end else begin
        prev_d[c] = 1'b0;
        idx_d[c]  = 3'd0;
      end
    end
  end

  // PWM gate: the widened compare lets DUTY = 2**PWM_BITS mean always on
  always_comb begin
    pwm_d = pwm_q + PWM_BITS'(1);
    on_s  = ({1'b0, pwm_q} < DUTY);
    r_d   = {NUM_RGB{1'b0}};
    g_d   = {NUM_RGB{1'b0}};
    b_d   = {NUM_RGB{1'b0}};
    for (int c = 0; c < NUM_RGB; c++) begin
      r_d[c] = idx_q[c][0] & on_s;
      g_d[c] = idx_q[c][1] & on_s;
      b_d[c] = idx_q[c][2] & on_s;
    end
  end

  // State registers for the LED, switch and RGB paths
  always_ff @(posedge clk_peripheral or negedge resetn) begin
    if (!resetn) begin
      led_q   <= {NUM_LED{1'b0}};
      sync1_q <= {NUM_LED{1'b0}};
      sync2_q <= {NUM_LED{1'b0}};
      db_q    <= {NUM_LED{1'b0}};
      cnt_q   <= {(NUM_LED * CW){1'b0}};
      prev_q  <= {NUM_RGB{1'b0}};
      idx_q   <= {(NUM_RGB * 3){1'b0}};
      pwm_q   <= {PWM_BITS{1'b0}};
      r_q     <= {NUM_RGB{1'b0}};
      g_q     <= {NUM_RGB{1'b0}};
      b_q     <= {NUM_RGB{1'b0}};
    end else begin
      led_q   <= led_d;
      sync1_q <= sw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  // Debounced switches appear at the LED bank position; all other bits read as zero
  always_comb begin
    gpio_i = {GPIO_W{1'b0}};
    gpio_i[LED_BASE +: NUM_LED] = db_q;
  end

  assign led   = led_q;
  assign led_r = r_q;
  assign led_g = g_q;
  assign led_b = b_q;

  // Not every GPIO bit belongs to this bank
  logic unused_s;
  assign unused_s = ^{gpio_o, gpio_t};

`ifdef SW_CHANGE_IRQ_EN
  logic [NUM_LED-1:0] db_prev_q;
  logic               ack_prev_q, ack_prev_d;
  logic               irq_q, irq_d;
  logic               db_chg_s, ack_rise_s;

  // Raise on any accepted switch change, clear on an ack edge; a raise beats a clear
  always_comb begin
    db_chg_s   = (db_q != db_prev_q);
    ack_rise_s = gpio_t[IRQ_ACK_BIT] & gpio_o[IRQ_ACK_BIT] & ~ack_prev_q;
    if (gpio_t[IRQ_ACK_BIT]) begin
      ack_prev_d = gpio_o[IRQ_ACK_BIT];
    end else begin
      ack_prev_d = 1'b0;
    end
    if (db_chg_s) begin
      irq_d = 1'b1;
    end else if (ack_rise_s) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // Interrupt state and edge trackers
  always_ff @(posedge clk_peripheral or negedge resetn) begin
    if (!resetn) begin
      db_prev_q  <= {NUM_LED{1'b0}};
      ack_prev_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      db_prev_q  <= db_q;
      ack_prev_q <= ack_prev_d;
      irq_q      <= irq_d;
    end
  end

  assign sw_irq = irq_q;
`else
  logic unused_ack_s;
  assign unused_ack_s = gpio_o[IRQ_ACK_BIT] ^ gpio_t[IRQ_ACK_BIT];
  assign sw_irq = 1'b0;
`endif

endmodule
